msg_schedule: RTL and testbench

MSG_SCHEDULE -- requirements
Module: msg_schedule

---
 rtl/msg_schedule_if.sv | 18 +
 rtl/msg_schedule.sv | 75 +++++++
 tb/tb_msg_schedule.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/msg_schedule_if.sv
// msg_schedule_if: handshake/bus bundle between a block producer and the message scheduler
// master drives start, word_in and word_valid, and observes word_ready, w_out, w_valid, w_idx, busy and done.
// slave is the scheduler side of the same signals.
interface msg_schedule_if;
    logic        start;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] w_out;
    logic        w_valid;
    logic [5:0]  w_idx;
    logic        busy;
    logic        done;
    modport master (output start, word_in, word_valid,
                    input  word_ready, w_out, w_valid, w_idx, busy, done);
    modport slave  (input  start, word_in, word_valid,
                    output word_ready, w_out, w_valid, w_idx, busy, done);
endinterface

// File: rtl/msg_schedule.sv
// msg_schedule: SHA-256 message schedule, loads 16 words and expands them to W[0..63]
// clk/rst: rising-edge clock, asynchronous active-high reset.
// bus.start/word_in/word_valid/word_ready: block request and word load handshake.
// bus.w_out/w_valid/w_idx: registered schedule word stream; bus.busy/done: status.
module msg_schedule (
    input logic          clk,
    input logic          rst,
    msg_schedule_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
    state_t      state;
    logic [5:0]  t;
    logic [31:0] win [16];
    logic [31:0] w_out_r;
    logic [5:0]  w_idx_r;
    logic        w_valid_r;
    logic        done_r;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] w_new;
    logic [31:0] shift_in;
    logic        shift_en;
    // win[15] is W[t-1], so W[t-k] lives in win[16-k]
    always_comb begin
        s0       = {win[1][6:0], win[1][31:7]} ^ {win[1][17:0], win[1][31:18]} ^ (win[1] >> 3);
        s1       = {win[14][16:0], win[14][31:17]} ^ {win[14][18:0], win[14][31:19]} ^ (win[14] >> 10);
        w_new    = s1 + win[9] + s0 + win[0];
        shift_in = (state == LOAD) ? bus.word_in : w_new;
        shift_en = ((state == LOAD) && bus.word_valid) || (state == EXPAND);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            w_out_r   <= '0;
            w_idx_r   <= '0;
            w_valid_r <= 1'b0;
            done_r    <= 1'b0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            w_valid_r <= 1'b0;
            done_r    <= 1'b0;
            if (shift_en) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15]   <= shift_in;
                w_out_r   <= shift_in;
                w_idx_r   <= t;
                w_valid_r <= 1'b1;
            end
            case (state)
                IDLE:    if (bus.start) begin
                             state <= LOAD;
                             t     <= '0;
                         end
                LOAD:    if (bus.word_valid) begin
                             t <= t + 6'd1;
                             if (t == 6'd15) state <= EXPAND;
                         end
                EXPAND:  if (t == 6'd63) state <= DONE;
                         else t <= t + 6'd1;
                DONE:    begin
                             done_r <= 1'b1;
                             state  <= IDLE;
                         end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.w_out      = w_out_r;
    assign bus.w_idx      = w_idx_r;
    assign bus.w_valid    = w_valid_r;
    assign bus.done       = done_r;
    assign bus.busy       = (state == LOAD) || (state == EXPAND);
    assign bus.word_ready = (state == LOAD);
endmodule

// File: tb/tb_msg_schedule.sv
// tb_msg_schedule: scoreboard bench for msg_schedule using directed blocks
module tb_msg_schedule;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    msg_schedule_if bus();
    msg_schedule dut (.clk(clk), .rst(rst), .bus(bus));
    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sched_t [64];
    typedef struct packed {logic [5:0] idx; logic [31:0] val;} exp_t;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic prev_valid = 1'b0;
    logic [5:0] prev_idx = '0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic void model(input blk_t m, output sched_t w);
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++)
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    endfunction
    // monitor: pops the scoreboard on every presented word, checks done placement
    always @(negedge clk) begin
        exp_t e;
        if (bus.w_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_w: got w_idx %0d w_out %h, expected no output", bus.w_idx, bus.w_out);
            end else begin
                e = q.pop_front();
                chk("w_idx", {26'd0, bus.w_idx}, {26'd0, e.idx});
                chk("w_out", bus.w_out, e.val);
            end
            if (bus.w_idx > 6'd16) chk("back_to_back", {31'd0, prev_valid}, 32'd1);
        end
        if (bus.done) begin
            done_cnt++;
            chk("done_after_w63", {25'd0, prev_valid, prev_idx}, {25'd0, 1'b1, 6'd63});
        end
        prev_valid = bus.w_valid;
        prev_idx = bus.w_idx;
    end
    task automatic push_block(input blk_t m, input bit abc);
        sched_t w;
        model(m, w);
        if (abc) begin
            w[16] = 32'h61626380;
            w[17] = 32'h000F0000;
        end
        for (int i = 0; i < 64; i++) q.push_back({i[5:0], w[i]});
    endtask
    task automatic wait_idx(input logic [5:0] n);
        for (int c = 0; c < 200 && !(bus.w_valid && bus.w_idx == n); c++) begin
            @(posedge clk);
            #1;
        end
        chk("reach_idx", {26'd0, bus.w_idx}, {26'd0, n});
    endtask
    task automatic load_words(input blk_t m, input int gap, input bit poke);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_load", {31'd0, bus.busy}, 32'd1);
        chk("ready_load", {31'd0, bus.word_ready}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.start = 1'b0;
                bus.word_valid = 1'b0;
                bus.word_in = $urandom;
                @(posedge clk);
                #1;
            end
            bus.word_valid = 1'b1;
            bus.word_in = m[i];
            bus.start = poke && (i == 5);
            @(posedge clk);
            #1;
        end
        bus.word_valid = 1'b0;
        bus.start = 1'b0;
    endtask
    task automatic run_block(input blk_t m, input int gap, input bit poke, input bit abc);
        int d0;
        push_block(m, abc);
        d0 = done_cnt;
        load_words(m, gap, poke);
        if (poke) begin
            wait_idx(6'd30);
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        for (int c = 0; c < 200 && done_cnt == d0; c++) @(negedge clk);
        chk("done_seen", done_cnt, d0 + 1);
        repeat (5) @(posedge clk);
        #1;
        chk("done_once", done_cnt, d0 + 1);
        chk("all_popped", q.size(), 0);
        chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    endtask
    initial begin
        blk_t abc_m, zero_m, ones_m, ramp_m;
        int d0;
        for (int i = 0; i < 16; i++) begin
            abc_m[i] = '0;
            zero_m[i] = '0;
            ones_m[i] = 32'hFFFFFFFF;
            ramp_m[i] = i * 32'h01010101 + 32'h1357_9BDF;
        end
        abc_m[0] = 32'h61626380;
        abc_m[15] = 32'h00000018;
        bus.start = 1'b0;
        bus.word_in = '0;
        bus.word_valid = 1'b0;
        #1;
        chk("rst_w_valid", {31'd0, bus.w_valid}, 32'd0);
        chk("rst_w_out", bus.w_out, 32'd0);
        chk("rst_w_idx", {26'd0, bus.w_idx}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_ready", {31'd0, bus.word_ready}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_block(abc_m, 0, 1'b0, 1'b1);
        run_block(abc_m, 2, 1'b0, 1'b1);
        run_block(zero_m, 0, 1'b0, 1'b0);
        run_block(abc_m, 0, 1'b1, 1'b1);
        run_block(ones_m, 1, 1'b0, 1'b0);
        push_block(ramp_m, 1'b0);
        d0 = done_cnt;
        load_words(ramp_m, 0, 1'b0);
        wait_idx(6'd40);
        rst = 1'b1;
        #1;
        chk("abort_w_valid", {31'd0, bus.w_valid}, 32'd0);
        chk("abort_w_out", bus.w_out, 32'd0);
        chk("abort_w_idx", {26'd0, bus.w_idx}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_ready", {31'd0, bus.word_ready}, 32'd0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.word_valid = 1'b1;
            bus.word_in = $urandom;
            @(posedge clk);
            #1;
            chk("no_start_ready", {31'd0, bus.word_ready}, 32'd0);
        end
        bus.word_valid = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        run_block(ramp_m, 0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
